// File: rtl/audio_serializer.sv
// audio_serializer: parallel 16-bit stereo samples to an I2S stream
// (MCLK, LRCK, SCK, SDIN) for the on-board DAC.
// Both channels are re-sampled once per frame of 128*SCK_HALF clk cycles;
// sample_tick pulses on the latch cycle for upstream pacing.
// Optional feature: define AUDIO_SERIALIZER_CENTER_EN to subtract 16'h4000
// from each channel before it is latched (mute still latches exactly 0).
module audio_serializer #(
  parameter int MCLK_HALF = 2,
  parameter int SCK_HALF  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] audio_left,
  input  logic [15:0] audio_right,
  input  logic        mute,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin,
  output logic        sample_tick
);

  localparam int F  = 128 * SCK_HALF;
  localparam int FW = $clog2(F);
  localparam int SB = $clog2(SCK_HALF);
  localparam int MW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;

  localparam logic [FW-1:0] FRAME_LAST = FW'(F - 1);
  localparam logic [MW-1:0] MCLK_LAST  = MW'(MCLK_HALF - 1);

  logic [FW-1:0] frame_cnt;
  logic [FW-1:0] frame_nxt;
  logic [5:0]    bit_nxt;
  logic          bit_start;
  logic          latch_now;
  logic [MW-1:0] mclk_cnt;
  logic [15:0]   shadow_l;
  logic [15:0]   shadow_r;
  logic [15:0]   shift_reg;

  // Value latched into a shadow register for one channel.
  function automatic logic [15:0] latch_value(input logic [15:0] sample,
                                              input logic        muted);
    logic [15:0] v;
    v = '0;
    if (!muted) begin
`ifdef AUDIO_SERIALIZER_CENTER_EN
      v = sample - 16'h4000;
`else
      v = sample;
`endif
    end
    return v;
  endfunction

  // Next frame position; all outputs are registered from it so they line
  // up with the counter value on the same edge.
  always_comb begin
    frame_nxt = (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FW'(1);
    bit_nxt   = frame_nxt[FW-1 -: 6];
    bit_start = (frame_nxt[SB:0] == '0);
    latch_now = (frame_nxt == FRAME_LAST);
  end

  // Free-running MCLK divider, independent of the frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mclk_cnt   <= '0;
      audio_mclk <= 1'b0;
    end else if (mclk_cnt == MCLK_LAST) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      mclk_cnt   <= '0;
      audio_mclk <= ~audio_mclk;
    end else begin
      mclk_cnt   <= mclk_cnt + MW'(1);
    end
  end

  // Frame counter, sample latch, shift register and serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: shadows and shift register are reset too, so the first frame
      // after reset transmits all zeros instead of stale data.
      frame_cnt   <= '0;
      shadow_l    <= '0;
      shadow_r    <= '0;
      shift_reg   <= '0;
      audio_lrck  <= 1'b0;
      audio_sck   <= 1'b0;
      audio_sdin  <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      frame_cnt   <= frame_nxt;
      audio_sck   <= frame_nxt[SB];
      audio_lrck  <= bit_nxt[5];
      sample_tick <= latch_now;

      if (latch_now) begin
        shadow_l <= latch_value(audio_left, mute);
        shadow_r <= latch_value(audio_right, mute);
      end

      // Data moves only at bit starts (SCK falling); one-bit I2S delay
      // puts the MSB in slot 1 of each half-frame.
      if (bit_start) begin
        if (bit_nxt == 6'd1) begin
          audio_sdin <= shadow_l[15];
          shift_reg  <= {shadow_l[14:0], 1'b0};
        end else if (bit_nxt == 6'd33) begin
          audio_sdin <= shadow_r[15];
          shift_reg  <= {shadow_r[14:0], 1'b0};
        end else if (bit_nxt[4:0] >= 5'd2 && bit_nxt[4:0] <= 5'd16) begin
          audio_sdin <= shift_reg[15];
          shift_reg  <= {shift_reg[14:0], 1'b0};
        end else begin
          audio_sdin <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_serializer.sv
// Directed bench for audio_serializer: default instance (SCK_HALF=4,
// MCLK_HALF=2) and a fast instance (SCK_HALF=1, MCLK_HALF=1).
// Expectations follow AUDIO_SERIALIZER_CENTER_EN when it is defined.
module tb_audio_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] audio_left;
  logic [15:0] audio_right;
  logic        mute;

  logic mclk0, lrck0, sck0, sdin0, tick0;
  logic mclk1, lrck1, sck1, sdin1, tick1;

  logic sel;
  logic s_mclk, s_lrck, s_sck, s_sdin, s_tick;

  int n_vec = 0;
  int n_err = 0;
  int cur_sh, cur_mh, cur_f;

  always #5 clk = ~clk;

  audio_serializer dut0 (
    .clk(clk), .rst(rst), .audio_left(audio_left), .audio_right(audio_right),
    .mute(mute), .audio_mclk(mclk0), .audio_lrck(lrck0), .audio_sck(sck0),
    .audio_sdin(sdin0), .sample_tick(tick0)
  );

  audio_serializer #(.MCLK_HALF(1), .SCK_HALF(1)) dut1 (
    .clk(clk), .rst(rst), .audio_left(audio_left), .audio_right(audio_right),
    .mute(mute), .audio_mclk(mclk1), .audio_lrck(lrck1), .audio_sck(sck1),
    .audio_sdin(sdin1), .sample_tick(tick1)
  );

  assign s_mclk = sel ? mclk1 : mclk0;
  assign s_lrck = sel ? lrck1 : lrck0;
  assign s_sck  = sel ? sck1  : sck0;
  assign s_sdin = sel ? sdin1 : sdin0;
  assign s_tick = sel ? tick1 : tick0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Value the DUT should transmit for a sample latched with the given mute.
  function automatic logic [15:0] conv(input logic [15:0] x, input logic m);
    logic [15:0] v;
    if (m) v = 16'h0000;
    else begin
`ifdef AUDIO_SERIALIZER_CENTER_EN
      v = x - 16'h4000;
`else
      v = x;
`endif
    end
    return v;
  endfunction

  // Expected sdin per bit slot b (bit b of the result).
  function automatic logic [63:0] exp_frame(input logic [15:0] l,
                                            input logic [15:0] r);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < 16; i++) begin
      f[1 + i]  = l[15 - i];
      f[33 + i] = r[15 - i];
    end
    return f;
  endfunction

  // Count cycles from reset release to the first tick; data must stay 0.
  task automatic wait_first_tick(input string tag);
    int n;
    int ones;
    n = 0;
    ones = 0;
    while (n < 4 * cur_f) begin
      @(negedge clk);
      n++;
      if (s_sdin) ones++;
      if (s_tick) break;
    end
    check({tag, "_latency"}, 64'(n), 64'(cur_f - 1));
    check({tag, "_zero_frame"}, 64'(ones), 64'd0);
  endtask

  // Observe one full frame starting right after a tick; ends at next tick.
  // Optionally changes audio_left at cycle chg_c and raises mute at mute_c.
  task automatic capture(input string tag, input logic [63:0] exp,
                         input int chg_c, input logic [15:0] chg_left,
                         input int mute_c);
    logic [63:0] bits;
    int   sck_e, lr_e, tk_e, st_e, mc_e, run;
    logic prev_m, seen;
    int   b, ph;
    bits = '0;
    sck_e = 0; lr_e = 0; tk_e = 0; st_e = 0; mc_e = 0;
    run = 0; seen = 1'b0; prev_m = s_mclk;
    for (int c = 0; c < cur_f; c++) begin
      @(negedge clk);
      b  = c / (2 * cur_sh);
      ph = c % (2 * cur_sh);
      if (ph == 0) bits[b] = s_sdin;
      else if (s_sdin !== bits[b]) st_e++;
      if (s_sck !== (ph >= cur_sh)) sck_e++;
      if (s_lrck !== (b >= 32)) lr_e++;
      if (s_tick !== (c == cur_f - 1)) tk_e++;
      if (s_mclk !== prev_m) begin
        if (seen && run != cur_mh) mc_e++;
        seen = 1'b1;
        run = 1;
      end else begin
        run++;
      end
      prev_m = s_mclk;
      if (c == chg_c) audio_left = chg_left;
      if (c == mute_c) mute = 1'b1;
    end
    check({tag, "_sdin"}, bits, exp);
    check({tag, "_sdin_stable"}, 64'(st_e), 64'd0);
    check({tag, "_sck"}, 64'(sck_e), 64'd0);
    check({tag, "_lrck"}, 64'(lr_e), 64'd0);
    check({tag, "_tick"}, 64'(tk_e), 64'd0);
    check({tag, "_mclk"}, 64'(mc_e + (seen ? 0 : 1)), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dut0"}, 64'({mclk0, lrck0, sck0, sdin0, tick0}), 64'd0);
    check({tag, "_dut1"}, 64'({mclk1, lrck1, sck1, sdin1, tick1}), 64'd0);
  endtask

  initial begin
    sel = 1'b0;
    cur_sh = 4; cur_mh = 2; cur_f = 512;
    rst = 1'b1;
    mute = 1'b0;
    audio_left  = 16'hA5A5;
    audio_right = 16'h0001;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_init");
    rst = 1'b0;

    wait_first_tick("first_tick");
    // Frame of A5A5 / 0001; inputs switched to 7FFF right away.
    audio_left  = 16'h7FFF;
    audio_right = 16'h7FFF;
    capture("serial_a5a5", exp_frame(conv(16'hA5A5, 1'b0), conv(16'h0001, 1'b0)),
            -1, 16'h0, -1);
    // 7FFF frame; left changes at b=5, mute rises at b=20.
    capture("midframe_7fff", exp_frame(conv(16'h7FFF, 1'b0), conv(16'h7FFF, 1'b0)),
            40, 16'h1234, 160);
    mute = 1'b0;
    audio_left  = 16'h4000;
    audio_right = 16'h0000;
    capture("muted", 64'd0, -1, 16'h0, -1);
    audio_left  = 16'h0000;
    audio_right = 16'h7FFF;
    capture("l4000_r0000", exp_frame(conv(16'h4000, 1'b0), conv(16'h0000, 1'b0)),
            -1, 16'h0, -1);
    mute = 1'b1;
    capture("l0000_r7fff", exp_frame(conv(16'h0000, 1'b0), conv(16'h7FFF, 1'b0)),
            -1, 16'h0, -1);
    mute = 1'b0;
    audio_left  = 16'h1234;
    audio_right = 16'h8001;
    capture("mute_latched", 64'd0, -1, 16'h0, -1);

    // Reset in the middle of a frame.
    repeat (100) @(negedge clk);
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_reset_outputs("reset_mid");
    end
    rst = 1'b0;
    wait_first_tick("after_mid_reset");
    capture("after_reset_1234", exp_frame(conv(16'h1234, 1'b0), conv(16'h8001, 1'b0)),
            -1, 16'h0, -1);

    // Fast instance: SCK_HALF=1, MCLK_HALF=1.
    sel = 1'b1;
    cur_sh = 1; cur_mh = 1; cur_f = 128;
    rst = 1'b1;
    audio_left  = 16'hA5A5;
    audio_right = 16'h0001;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_fast");
    rst = 1'b0;
    wait_first_tick("fast_first_tick");
    capture("fast_a5a5", exp_frame(conv(16'hA5A5, 1'b0), conv(16'h0001, 1'b0)),
            -1, 16'h0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
